// File: rtl/timer_seq_pkg.sv
// rtl/timer_seq_pkg.sv - shared opcode/state types for the timer command sequencer
package timer_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_START  = 3'd1,
    OP_STOP   = 3'd2,
    OP_RST    = 3'd3,
    OP_UPDATE = 3'd4,
    OP_ARM    = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_UPD = 2'd2
  } state_e;

endpackage

// File: rtl/timer_cmd_fifo.sv
// rtl/timer_cmd_fifo.sv - sync command FIFO with flush and occupancy output
module timer_cmd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  // Flush wins over everything; full/empty guards keep the FIFO safe against careless callers.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/timer_cmd_seq.sv
// rtl/timer_cmd_seq.sv - queues timer commands and issues single-cycle per-timer cfg pulses
module timer_cmd_seq
  import timer_seq_pkg::*;
#(
  parameter int N_TIMERS    = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int UPD_TIMEOUT = 255,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [OP_W-1:0]     cmd_op_i,
  input  logic [N_TIMERS-1:0] cmd_mask_i,
  input  logic                flush_i,
  output logic [N_TIMERS-1:0] timer_start_o,
  output logic [N_TIMERS-1:0] timer_stop_o,
  output logic [N_TIMERS-1:0] timer_rst_o,
  output logic [N_TIMERS-1:0] timer_update_o,
  output logic [N_TIMERS-1:0] timer_arm_o,
  input  logic [N_TIMERS-1:0] timer_pending_i,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [LW-1:0]       fifo_level_o
);

  localparam int DW = OP_W + N_TIMERS;
  localparam int CW = $clog2(UPD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(UPD_TIMEOUT - 1);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [N_TIMERS-1:0] mask_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]       fifo_rdata;

  assign cmd_ready_o = !fifo_full && !flush_i;
  assign fifo_push   = cmd_valid_i && cmd_ready_o;
  assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;

  timer_cmd_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .wdata_i ({cmd_op_i, cmd_mask_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fifo_pop) begin
        op_q   <= op_e'(fifo_rdata[DW-1 -: OP_W]);
        mask_q <= fifo_rdata[N_TIMERS-1:0];
      end
    end
  end

  // Flush overrides every exit, so a timeout can never be reported in a flush cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fifo_pop  = 1'b0;
    timeout_o = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_d   = '0;
          state_d = (op_q == OP_UPDATE) ? ST_WAIT_UPD : ST_IDLE;
        end
        ST_WAIT_UPD: begin
          if ((timer_pending_i & mask_q) == '0) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_o = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pulses decode registered state only, so they drop the instant reset asserts.
  always_comb begin
    timer_start_o  = '0;
    timer_stop_o   = '0;
    timer_rst_o    = '0;
    timer_update_o = '0;
    timer_arm_o    = '0;
    if (state_q == ST_ISSUE) begin
      case (op_q)
        OP_START:  timer_start_o  = mask_q;
        OP_STOP:   timer_stop_o   = mask_q;
        OP_RST:    timer_rst_o    = mask_q;
        OP_UPDATE: timer_update_o = mask_q;
        OP_ARM:    timer_arm_o    = mask_q;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cmd_seq.sv
// tb/tb_timer_cmd_seq.sv - scoreboard bench for timer_cmd_seq
module tb_timer_cmd_seq;
  import timer_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid, cmd_ready, flush, busy, timeout;
  logic [2:0] cmd_op;
  logic [3:0] cmd_mask, pend;
  logic [3:0] t_start, t_stop, t_rst, t_upd, t_arm;
  logic [2:0] level;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int       cyc;
    logic [3:0] st, sp, rs, up, ar;
    logic     to;
  } ev_t;
  ev_t exp_q[$];

  timer_cmd_seq #(.N_TIMERS(4), .FIFO_DEPTH(4), .UPD_TIMEOUT(8)) dut (
    .clk_i(clk), .rstn_i(rstn), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_mask_i(cmd_mask), .flush_i(flush),
    .timer_start_o(t_start), .timer_stop_o(t_stop), .timer_rst_o(t_rst),
    .timer_update_o(t_upd), .timer_arm_o(t_arm), .timer_pending_i(pend),
    .busy_o(busy), .timeout_o(timeout), .fifo_level_o(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  task automatic ex(input int c, input int k, input logic [3:0] m);
    ev_t e;
    e.cyc = c; e.st = '0; e.sp = '0; e.rs = '0; e.up = '0; e.ar = '0; e.to = 1'b0;
    case (k)
      1: e.st = m;
      2: e.sp = m;
      3: e.rs = m;
      4: e.up = m;
      5: e.ar = m;
      default: e.to = 1'b1;
    endcase
    exp_q.push_back(e);
  endtask

  // Call at posedge+1; returns at posedge+1 with p = edge count of the accepting edge.
  task automatic push(input logic [2:0] op, input logic [3:0] m, output int p);
    logic r;
    int   n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = m;
    do begin
      @(negedge clk); r = cmd_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 200);
    if (!r) chk("push_accept_bound", 0, 1);
    p = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Monitor: every observed pulse/timeout event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && (|{t_start, t_stop, t_rst, t_upd, t_arm, timeout})) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: cyc=%0d st=%b sp=%b rs=%b up=%b ar=%b to=%b, expected no event",
                 cyc, t_start, t_stop, t_rst, t_upd, t_arm, timeout);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.cyc == cyc && e.st == t_start && e.sp == t_stop && e.rs == t_rst &&
            e.up == t_upd && e.ar == t_arm && e.to == timeout)
          n_pass++;
        else
          $display("FAIL sb_event: got cyc=%0d st=%b sp=%b rs=%b up=%b ar=%b to=%b expected cyc=%0d st=%b sp=%b rs=%b up=%b ar=%b to=%b",
                   cyc, t_start, t_stop, t_rst, t_upd, t_arm, timeout,
                   e.cyc, e.st, e.sp, e.rs, e.up, e.ar, e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, p0, pr;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; flush = 1'b0; pend = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_pulses", int'(|{t_start, t_stop, t_rst, t_upd, t_arm, timeout}), 0);
    sync(); rstn = 1'b1;
    sync();

    // Single START
    push(OP_START, 4'b0101, p);
    ex(p + 1, 1, 4'b0101);
    at_neg(p + 1); chk("t1_busy_issue", int'(busy), 1);
    at_neg(p + 2); chk("t1_busy_idle", int'(busy), 0);
    sync();

    // Burst fills the queue behind a held UPDATE
    pend = 4'b0001;
    push(OP_UPDATE, 4'b0001, p0);
    ex(p0 + 1, 4, 4'b0001);
    push(OP_START, 4'b0001, p);
    push(OP_STOP, 4'b0010, p);
    push(OP_ARM, 4'b0100, p);
    push(OP_NOP, 4'b1111, p);
    at_neg(p0 + 4);
    chk("t2_level_full", int'(level), 4);
    chk("t2_ready_full", int'(cmd_ready), 0);
    sync(); pend = 4'b0000;
    ex(p0 + 7, 1, 4'b0001);
    ex(p0 + 9, 2, 4'b0010);
    ex(p0 + 11, 5, 4'b0100);
    ex(p0 + 15, 3, 4'b1000);
    push(OP_RST, 4'b1000, pr);
    chk("t2_rst_accept_edge", pr - p0, 8);
    at_neg(p0 + 16); chk("t2_busy_done", int'(busy), 0);
    sync();

    // UPDATE with pending released after 3 wait cycles
    pend = 4'b0010;
    push(OP_UPDATE, 4'b0010, p0);
    ex(p0 + 1, 4, 4'b0010);
    push(OP_START, 4'b0100, p);
    ex(p0 + 7, 1, 4'b0100);
    repeat (4) sync();
    pend = 4'b0000;
    at_neg(p0 + 8); chk("t3_busy_done", int'(busy), 0);
    sync();

    // UPDATE with pending stuck high times out
    pend = 4'b1000;
    push(OP_UPDATE, 4'b1000, p0);
    ex(p0 + 1, 4, 4'b1000);
    ex(p0 + 9, 0, 4'b0000);
    at_neg(p0 + 8); chk("t4_busy_wait", int'(busy), 1);
    at_neg(p0 + 10); chk("t4_busy_after_tmo", int'(busy), 0);
    sync(); pend = 4'b0000;

    // Mask 0 UPDATE and reserved opcode are consumed silently
    pend = 4'b1111;
    push(OP_UPDATE, 4'b0000, p0);
    at_neg(p0 + 2); chk("t5_mask0_wait", int'(busy), 1);
    at_neg(p0 + 3); chk("t5_mask0_idle", int'(busy), 0);
    sync(); pend = 4'b0000;
    push(OP_RSV7, 4'b1111, p0);
    at_neg(p0 + 1); chk("t5_rsv_issue", int'(busy), 1);
    at_neg(p0 + 2); chk("t5_rsv_idle", int'(busy), 0);
    sync();

    // Flush during WAIT_UPD with 3 queued, concurrent push offered
    pend = 4'b0001;
    push(OP_UPDATE, 4'b0001, p0);
    ex(p0 + 1, 4, 4'b0001);
    push(OP_START, 4'b0001, p);
    push(OP_STOP, 4'b0001, p);
    push(OP_ARM, 4'b0001, p);
    flush = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RST; cmd_mask = 4'b1111;
    at_neg(p0 + 3);
    chk("t6_level_pre", int'(level), 3);
    chk("t6_ready_flush", int'(cmd_ready), 0);
    sync(); flush = 1'b0; cmd_valid = 1'b0;
    at_neg(p0 + 4);
    chk("t6_level_post", int'(level), 0);
    chk("t6_busy_post", int'(busy), 0);
    chk("t6_ready_post", int'(cmd_ready), 1);
    at_neg(p0 + 14);
    sync(); pend = 4'b0000;

    // Reset asserted during ISSUE
    push(OP_ARM, 4'b1111, p0);
    @(posedge clk); #1; rstn = 1'b0;
    #1;
    chk("t7_rst_pulses", int'(|{t_start, t_stop, t_rst, t_upd, t_arm}), 0);
    chk("t7_rst_timeout", int'(timeout), 0);
    chk("t7_rst_busy", int'(busy), 0);
    chk("t7_rst_ready", int'(cmd_ready), 1);
    chk("t7_rst_level", int'(level), 0);
    sync(); rstn = 1'b1;
    repeat (5) sync();

    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
